// File: rtl/th_pingpong_line_bram.sv
// th_pingpong_line_bram
//   Packs the top PIX_BITS of each incoming 8-bit threshold/class pixel into
//   one wide word per image row. Each row is written into one of two frame
//   banks (ping-pong) of an inferred simple-dual-port RAM. A completed frame
//   is published to the quad/segment reader. The reader random-reads rows
//   from the published bank until it releases it.
//
//   Optional feature macro: TH_BRAM_SHORT_PAD_EN
//     defined   : a short line (last before column COL_SIZE-1) is committed
//                 with the remaining columns reading 0
//     undefined : a short line is discarded and the row index is reused
//
// Ports
//   clk, rst_n           clock, synchronous active-low reset
//   i_s_valid/o_s_ready  pixel handshake; i_s_data pixel
//   i_s_fstart, i_s_last first pixel of frame / last pixel of row
//   o_row_done/o_row_idx pulse when a row is written to RAM, with its index
//   o_frame_valid/bank   published bank for the reader
//   i_frame_release      reader done with the published bank
//   rd_en/rd_addr/rd_data  registered row read from the published bank
//   o_err_short/long/sync  one-cycle error pulses
module th_pingpong_line_bram #(
  parameter int COL_SIZE  = 640,
  parameter int ROW_SIZE  = 360,
  parameter int PIX_BITS  = 2,
  parameter int DATA_IN_W = 8,
  parameter int ADDR_W    = 9
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_s_valid,
  input  logic [DATA_IN_W-1:0]         i_s_data,
  input  logic                         i_s_fstart,
  input  logic                         i_s_last,
  output logic                         o_s_ready,
  output logic                         o_row_done,
  output logic [ADDR_W-1:0]            o_row_idx,
  output logic                         o_frame_valid,
  output logic                         o_frame_bank,
  input  logic                         i_frame_release,
  input  logic                         rd_en,
  input  logic [ADDR_W-1:0]            rd_addr,
  output logic [COL_SIZE*PIX_BITS-1:0] rd_data,
  output logic                         o_err_short,
  output logic                         o_err_long,
  output logic                         o_err_sync
);
  localparam int LINE_W = COL_SIZE * PIX_BITS;
  localparam int COL_W  = (COL_SIZE > 1) ? $clog2(COL_SIZE) : 1;
`ifdef TH_BRAM_SHORT_PAD_EN
  localparam bit PAD_EN = 1'b1;
`else
  localparam bit PAD_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, WRITE, WAIT_BANK} state_t;

  state_t              state;
  logic [LINE_W-1:0]   line, line_ins, wr_line;
  logic [COL_W-1:0]    col;
  logic [ADDR_W-1:0]   row;
  logic                wr_bank, wr_bank_q;
  logic [PIX_BITS-1:0] pix;
  logic                acc, at_end, restart, commit, discard, frame_end, pub_free;
  logic                data_unused;

  logic [LINE_W-1:0] ram [0:(2**(ADDR_W+1))-1];

  // Only the MSBs of each pixel are kept.
  assign data_unused = ^i_s_data;

  always_comb begin
    pix      = i_s_data[DATA_IN_W-1 -: PIX_BITS];
    line_ins = line;
    line_ins[int'(col)*PIX_BITS +: PIX_BITS] = pix;
    acc      = i_s_valid & o_s_ready;
    at_end   = (col == COL_W'(COL_SIZE-1));
    // fstart anywhere but the very first slot of a frame aborts and restarts
    restart  = (state == WRITE) & acc & i_s_fstart & ((col != '0) | (row != '0));
    commit   = (state == WRITE) & acc & ~restart & (at_end | (i_s_last & PAD_EN));
    discard  = (state == WRITE) & acc & ~restart & ~at_end & i_s_last & ~PAD_EN;
    frame_end = commit & (row == ADDR_W'(ROW_SIZE-1));
    // release in the same cycle frees the bank before frame completion is seen
    pub_free = ~o_frame_valid | i_frame_release;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      line          <= '0;
      col           <= '0;
      row           <= '0;
      wr_bank       <= 1'b0;
      wr_bank_q     <= 1'b0;
      wr_line       <= '0;
      o_s_ready     <= 1'b0;
      o_row_done    <= 1'b0;
      o_row_idx     <= '0;
      o_frame_valid <= 1'b0;
      o_frame_bank  <= 1'b0;
      o_err_short   <= 1'b0;
      o_err_long    <= 1'b0;
      o_err_sync    <= 1'b0;
    end else begin
      o_row_done  <= 1'b0;
      o_err_short <= 1'b0;
      o_err_long  <= 1'b0;
      o_err_sync  <= 1'b0;
      if (i_frame_release) o_frame_valid <= 1'b0;
      case (state)
        IDLE: begin
          o_s_ready <= 1'b1;
          if (acc) begin
            if (i_s_fstart) begin
              line  <= LINE_W'(pix);
              col   <= COL_W'(1);
              row   <= '0;
              state <= WRITE;
            end else begin
              o_err_sync <= 1'b1;
            end
          end
        end
        WRITE: begin
          o_s_ready <= 1'b1;
          if (restart) begin
            o_err_sync <= 1'b1;
            line       <= LINE_W'(pix);
            col        <= COL_W'(1);
            row        <= '0;
          end else if (commit) begin
            // write lands next cycle, together with o_row_done
            wr_line     <= line_ins;
            wr_bank_q   <= wr_bank;
            o_row_idx   <= row;
            o_row_done  <= 1'b1;
            o_err_long  <= at_end & ~i_s_last;
            o_err_short <= ~at_end;
            line        <= '0;
            col         <= '0;
            if (frame_end) begin
              row <= '0;
              if (pub_free) begin
                o_frame_valid <= 1'b1;
                o_frame_bank  <= wr_bank;
                wr_bank       <= ~wr_bank;
                state         <= IDLE;
              end else begin
                o_s_ready <= 1'b0;
                state     <= WAIT_BANK;
              end
            end else begin
              row <= row + ADDR_W'(1);
            end
          end else if (discard) begin
            o_err_short <= 1'b1;
            line        <= '0;
            col         <= '0;
          end else if (acc) begin
            line <= line_ins;
            col  <= col + COL_W'(1);
          end
        end
        WAIT_BANK: begin
          o_s_ready <= 1'b0;
          if (i_frame_release) begin
            // swap: completed bank goes out, released bank becomes the write bank
            o_frame_valid <= 1'b1;
            o_frame_bank  <= wr_bank;
            wr_bank       <= o_frame_bank;
            o_s_ready     <= 1'b1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (o_row_done) ram[{wr_bank_q, o_row_idx}] <= wr_line;
  end

  // The freshly published last row may be read while its write is landing;
  // forward the pending line in that case.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      if (o_row_done && ({wr_bank_q, o_row_idx} == {o_frame_bank, rd_addr}))
        rd_data <= wr_line;
      else
        rd_data <= ram[{o_frame_bank, rd_addr}];
    end
  end

endmodule

// File: tb/tb_th_pingpong_line_bram.sv
// Scoreboard bench for th_pingpong_line_bram with COL_SIZE=8, ROW_SIZE=4,
// PIX_BITS=2. Expected row indices and read data are queued when stimulus
// is driven and compared by a negedge monitor when the DUT produces them.
module tb_th_pingpong_line_bram;
  localparam int COLS = 8, ROWS = 4, PB = 2, DW = 8, AW = 2, LW = COLS*PB;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          i_s_valid = 1'b0, i_s_fstart = 1'b0, i_s_last = 1'b0;
  logic [DW-1:0] i_s_data = '0;
  logic          o_s_ready, o_row_done, o_frame_valid, o_frame_bank;
  logic [AW-1:0] o_row_idx;
  logic          i_frame_release = 1'b0, rd_en = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [LW-1:0] rd_data;
  logic          o_err_short, o_err_long, o_err_sync;

  th_pingpong_line_bram #(.COL_SIZE(COLS), .ROW_SIZE(ROWS), .PIX_BITS(PB),
                          .DATA_IN_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .i_s_valid(i_s_valid), .i_s_data(i_s_data),
    .i_s_fstart(i_s_fstart), .i_s_last(i_s_last), .o_s_ready(o_s_ready),
    .o_row_done(o_row_done), .o_row_idx(o_row_idx), .o_frame_valid(o_frame_valid),
    .o_frame_bank(o_frame_bank), .i_frame_release(i_frame_release),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .o_err_short(o_err_short), .o_err_long(o_err_long), .o_err_sync(o_err_sync));

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int n_sync = 0, n_short = 0, n_long = 0;
  int idxq[$];
  logic [LW-1:0] rdq[$];
  logic [LW-1:0] last_rd = '0;
  logic rd_d = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  always @(posedge clk) rd_d <= rd_en;

  always @(negedge clk) begin
    if (o_err_sync)  n_sync++;
    if (o_err_short) n_short++;
    if (o_err_long)  n_long++;
    if (o_row_done) begin
      if (idxq.size() == 0) chk("row_done_unexpected", idxq.size(), 1);
      else chk("row_idx", o_row_idx, idxq.pop_front());
    end
    if (rd_d && rdq.size() != 0) begin
      last_rd = rdq.pop_front();
      chk("rd_data", rd_data, last_rd);
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic logic [DW-1:0] pix(input int c, input int k);
    logic [1:0] v;
    v = 2'((c + k) % 4);
    return {v, 6'h15};  // low bits are junk that must be dropped
  endfunction

  function automatic logic [LW-1:0] exp_line(input int k);
    logic [LW-1:0] l;
    l = '0;
    for (int c = 0; c < COLS; c++) l[c*PB +: PB] = 2'((c + k) % 4);
    return l;
  endfunction

  task automatic send(input logic [DW-1:0] d, input logic fs, input logic ls, input logic rel);
    int n;
    n = 0;
    while (!o_s_ready && n < 50) begin tick(); n++; end
    if (!o_s_ready) chk("ready_timeout", o_s_ready, 1);
    i_s_valid = 1'b1; i_s_data = d; i_s_fstart = fs; i_s_last = ls; i_frame_release = rel;
    tick();
    i_s_valid = 1'b0; i_s_fstart = 1'b0; i_s_last = 1'b0; i_frame_release = 1'b0;
  endtask

  // idx < 0: no row_done expected for this row
  task automatic send_row(input int k, input logic fs, input logic ls_en, input int idx,
                          input int ncols, input logic rel_last);
    for (int c = 0; c < ncols; c++) begin
      if (c == ncols-1 && idx >= 0) idxq.push_back(idx);
      send(pix(c, k), fs && c == 0, ls_en && c == ncols-1, rel_last && c == ncols-1);
    end
  endtask

  task automatic send_frame(input int k, input logic rel_last);
    for (int r = 0; r < ROWS; r++) send_row(k, r == 0, 1'b1, r, COLS, rel_last && r == ROWS-1);
  endtask

  task automatic rd_row(input int r, input logic [LW-1:0] exp);
    rd_en = 1'b1; rd_addr = AW'(r); rdq.push_back(exp);
    tick();
    rd_en = 1'b0;
  endtask

  task automatic release_pulse();
    i_frame_release = 1'b1; tick(); i_frame_release = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    repeat (3) tick();
    chk("rst_ready", o_s_ready, 0);
    chk("rst_fvalid", o_frame_valid, 0);
    chk("rst_rowdone", o_row_done, 0);
    rst_n = 1'b1;
    tick();
    chk("ready_after_rst", o_s_ready, 1);

    // frame A -> bank 0, published immediately
    send_frame(0, 1'b0);
    tick();
    chk("A_fvalid", o_frame_valid, 1);
    chk("A_bank", o_frame_bank, 0);
    chk("A_ready", o_s_ready, 1);
    for (int r = 0; r < ROWS; r++) rd_row(r, 16'hE4E4);
    tick(); tick();
    chk("rd_hold", rd_data, last_rd);

    // frame B with bank 0 still held -> WAIT_BANK
    send_frame(1, 1'b0);
    chk("B_wait_ready", o_s_ready, 0);
    tick();
    chk("B_wait_ready2", o_s_ready, 0);
    chk("B_bank_old", o_frame_bank, 0);
    release_pulse();
    chk("B_bank", o_frame_bank, 1);
    chk("B_fvalid", o_frame_valid, 1);
    chk("B_ready", o_s_ready, 1);
    for (int r = 0; r < ROWS; r++) rd_row(r, exp_line(1));

    // frame C completes in the same cycle as the release -> no WAIT_BANK
    send_frame(2, 1'b1);
    chk("C_ready", o_s_ready, 1);
    chk("C_bank", o_frame_bank, 0);
    chk("C_fvalid", o_frame_valid, 1);
    for (int r = 0; r < ROWS; r++) rd_row(r, exp_line(2));

    // frame D: fstart at row 2 col 5 restarts the frame
    send_row(3, 1'b1, 1'b1, 0, COLS, 1'b0);
    send_row(3, 1'b0, 1'b1, 1, COLS, 1'b0);
    send_row(3, 1'b0, 1'b0, -1, 5, 1'b0);
    send(pix(0, 3), 1'b1, 1'b0, 1'b0);
    for (int c = 1; c < COLS; c++) begin
      if (c == COLS-1) idxq.push_back(0);
      send(pix(c, 3), 1'b0, c == COLS-1, 1'b0);
    end
    tick();
    chk("D_err_sync", n_sync, 1);
    release_pulse();
    tick();
    chk("D_released", o_frame_valid, 0);
    for (int r = 1; r < ROWS; r++) send_row(3, 1'b0, 1'b1, r, COLS, 1'b0);
    tick();
    chk("D_fvalid", o_frame_valid, 1);
    chk("D_bank", o_frame_bank, 1);
    for (int r = 0; r < ROWS; r++) rd_row(r, exp_line(3));

    // frame E: short line at col 3, then a long line (no last)
    release_pulse();
    send_row(1, 1'b1, 1'b1, 0, COLS, 1'b0);
`ifdef TH_BRAM_SHORT_PAD_EN
    send_row(0, 1'b0, 1'b1, 1, 4, 1'b0);
    send_row(1, 1'b0, 1'b0, 2, COLS, 1'b0);
    send_row(1, 1'b0, 1'b1, 3, COLS, 1'b0);
`else
    send_row(0, 1'b0, 1'b1, -1, 4, 1'b0);
    send_row(1, 1'b0, 1'b0, 1, COLS, 1'b0);
    send_row(1, 1'b0, 1'b1, 2, COLS, 1'b0);
    send_row(1, 1'b0, 1'b1, 3, COLS, 1'b0);
`endif
    tick();
    chk("E_err_short", n_short, 1);
    chk("E_err_long", n_long, 1);
    chk("E_fvalid", o_frame_valid, 1);
    chk("E_bank", o_frame_bank, 0);
    rd_row(0, exp_line(1));
`ifdef TH_BRAM_SHORT_PAD_EN
    rd_row(1, 16'h00E4);
`else
    rd_row(1, exp_line(1));
`endif
    rd_row(2, exp_line(1));
    rd_row(3, exp_line(1));

    // beats in IDLE without fstart are dropped
    for (int i = 0; i < 3; i++) send(8'hC0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("idle_err_sync", n_sync, 4);

    // reset mid-frame
    send_row(0, 1'b1, 1'b0, -1, 3, 1'b0);
    rst_n = 1'b0;
    tick();
    chk("midrst_ready", o_s_ready, 0);
    chk("midrst_fvalid", o_frame_valid, 0);
    rst_n = 1'b1;
    tick();
    chk("postrst_ready", o_s_ready, 1);
    chk("postrst_fvalid", o_frame_valid, 0);
    tick(); tick();
    chk("sb_row_empty", idxq.size(), 0);
    chk("sb_rd_empty", rdq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
